// File: rtl/bsg_chip_link_loopback_gen.sv
// bsg_chip_link_loopback_gen
//   Per-channel link exerciser that sits between the core-side ready_and link
//   interfaces and the core. Each channel runs in one of three runtime modes:
//     00 buffered loopback (els_p-deep FIFO, 1-cycle latency, no bypass)
//     01 LFSR pattern generator on the outbound side plus LFSR checker on the
//        inbound side, with a saturating mismatch counter
//     10/11 sink (inbound accepted and dropped, outbound idle)
//   Optional macro BSG_LINK_LOOPBACK_GEN_STATS_EN adds per-channel 32-bit
//   wrapping counters of outbound (sent) and inbound (recv) handshakes.
//
// Ports
//   clk_i, reset_n_i         clock, synchronous active-low reset
//   mode_v_i, mode_i, seed_i  mode/seed load strobe (flushes every channel)
//   in_v_i, in_data_i, in_ready_and_o     inbound ready_and interface
//   out_v_o, out_data_o, out_ready_and_i  outbound ready_and interface
//   err_count_o               saturating checker mismatch count
//   sent_count_o, recv_count_o  (stats build only) handshake counters
module bsg_chip_link_loopback_gen #(
  parameter int unsigned        num_channels_p = 4,
  parameter int unsigned        width_p        = 16,
  parameter int unsigned        els_p          = 4,
  parameter logic [width_p-1:0] lfsr_taps_p    = width_p'(16'hB400),
  parameter int unsigned        err_width_p    = 8,
  parameter logic [1:0]         reset_mode_p   = 2'b00
) (
  input  logic                                      clk_i,
  input  logic                                      reset_n_i,
  input  logic                                      mode_v_i,
  input  logic [num_channels_p-1:0][1:0]            mode_i,
  input  logic [width_p-1:0]                        seed_i,
  input  logic [num_channels_p-1:0]                 in_v_i,
  input  logic [num_channels_p-1:0][width_p-1:0]    in_data_i,
  output logic [num_channels_p-1:0]                 in_ready_and_o,
  output logic [num_channels_p-1:0]                 out_v_o,
  output logic [num_channels_p-1:0][width_p-1:0]    out_data_o,
  input  logic [num_channels_p-1:0]                 out_ready_and_i,
  output logic [num_channels_p-1:0][err_width_p-1:0] err_count_o
`ifdef BSG_LINK_LOOPBACK_GEN_STATS_EN
  ,
  output logic [num_channels_p-1:0][31:0]           sent_count_o,
  output logic [num_channels_p-1:0][31:0]           recv_count_o
`endif
);

  localparam int unsigned ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int unsigned cnt_w_lp = $clog2(els_p + 1);
  localparam logic [1:0]  mode_loop_lp = 2'b00;
  localparam logic [1:0]  mode_gen_lp  = 2'b01;
  localparam logic [err_width_p-1:0] err_max_lp = '1;
  localparam logic [cnt_w_lp-1:0]    cnt_full_lp = cnt_w_lp'(els_p);

  // Channel state
  logic [num_channels_p-1:0][1:0]             r_mode, w_mode_n;
  logic [width_p-1:0]                         r_mem [num_channels_p][els_p];
  logic [num_channels_p-1:0][ptr_w_lp-1:0]    r_wptr, w_wptr_n;
  logic [num_channels_p-1:0][ptr_w_lp-1:0]    r_rptr, w_rptr_n;
  logic [num_channels_p-1:0][cnt_w_lp-1:0]    r_cnt, w_cnt_n;
  logic [num_channels_p-1:0][width_p-1:0]     r_gen, w_gen_n;
  logic [num_channels_p-1:0][width_p-1:0]     r_chk, w_chk_n;
  logic [num_channels_p-1:0][err_width_p-1:0] r_err, w_err_n;
  logic [num_channels_p-1:0]                  w_we;

  // Registered interface outputs, computed from next state
  logic [num_channels_p-1:0]                  r_out_v, w_out_v_n;
  logic [num_channels_p-1:0]                  r_in_ready, w_in_ready_n;
  logic [num_channels_p-1:0][width_p-1:0]     r_out_data, w_out_data_n;

  logic [num_channels_p-1:0]                  w_in_hs, w_out_hs;
  logic [width_p-1:0]                         w_seed;

  function automatic logic [width_p-1:0] lfsr_next(input logic [width_p-1:0] v);
    return {v[width_p-2:0], ^(v & lfsr_taps_p)};
  endfunction

  assign w_in_hs  = in_v_i & r_in_ready;
  assign w_out_hs = r_out_v & out_ready_and_i;
  // A zero seed would lock the LFSR at zero, so it is replaced by 1
  assign w_seed   = (seed_i == '0) ? width_p'(1) : seed_i;

  // Next-state and next-output logic for every channel
  always_comb begin
    w_mode_n     = r_mode;
    w_wptr_n     = r_wptr;
    w_rptr_n     = r_rptr;
    w_cnt_n      = r_cnt;
    w_gen_n      = r_gen;
    w_chk_n      = r_chk;
    w_err_n      = r_err;
    w_we         = '0;
    w_out_v_n    = '0;
    w_in_ready_n = '1;
    w_out_data_n = '0;

    for (int c = 0; c < num_channels_p; c++) begin
      if (mode_v_i) begin
        // Mode load flushes the channel; handshakes this cycle are ignored
        w_mode_n[c] = mode_i[c];
        w_wptr_n[c] = '0;
        w_rptr_n[c] = '0;
        w_cnt_n[c]  = '0;
        w_gen_n[c]  = w_seed;
        w_chk_n[c]  = w_seed;
        w_err_n[c]  = '0;
      end else begin
        case (r_mode[c])
          mode_loop_lp: begin
            if (w_in_hs[c]) begin
              w_we[c]     = 1'b1;
              w_wptr_n[c] = r_wptr[c] + ptr_w_lp'(1);
            end
            if (w_out_hs[c]) begin
              w_rptr_n[c] = r_rptr[c] + ptr_w_lp'(1);
            end
            if (w_in_hs[c] && !w_out_hs[c]) begin
              w_cnt_n[c] = r_cnt[c] + cnt_w_lp'(1);
            end else if (!w_in_hs[c] && w_out_hs[c]) begin
              w_cnt_n[c] = r_cnt[c] - cnt_w_lp'(1);
            end
          end
          mode_gen_lp: begin
            if (w_out_hs[c]) begin
              w_gen_n[c] = lfsr_next(r_gen[c]);
            end
            if (w_in_hs[c]) begin
              if ((in_data_i[c] != r_chk[c]) && (r_err[c] != err_max_lp)) begin
                w_err_n[c] = r_err[c] + err_width_p'(1);
              end
              w_chk_n[c] = lfsr_next(r_chk[c]);
            end
          end
          default: begin
          end
        endcase
      end

      case (w_mode_n[c])
        mode_loop_lp: begin
          w_out_v_n[c]    = (w_cnt_n[c] != '0);
          w_in_ready_n[c] = (w_cnt_n[c] != cnt_full_lp);
          // Word written this cycle into the new head slot is forwarded here
          if (w_we[c] && (r_wptr[c] == w_rptr_n[c])) begin
            w_out_data_n[c] = in_data_i[c];
          end else begin
            w_out_data_n[c] = r_mem[c][w_rptr_n[c]];
          end
        end
        mode_gen_lp: begin
          w_out_v_n[c]    = 1'b1;
          w_in_ready_n[c] = 1'b1;
          w_out_data_n[c] = w_gen_n[c];
        end
        default: begin
          w_out_v_n[c]    = 1'b0;
          w_in_ready_n[c] = 1'b1;
          w_out_data_n[c] = '0;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_mode     <= {num_channels_p{reset_mode_p}};
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_cnt      <= '0;
      r_gen      <= {num_channels_p{width_p'(1)}};
      r_chk      <= {num_channels_p{width_p'(1)}};
      r_err      <= '0;
      r_out_v    <= '0;
      r_in_ready <= '1;
      r_out_data <= {num_channels_p{(reset_mode_p == mode_gen_lp) ? width_p'(1) : width_p'(0)}};
    end else begin
      r_mode     <= w_mode_n;
      r_wptr     <= w_wptr_n;
      r_rptr     <= w_rptr_n;
      r_cnt      <= w_cnt_n;
      r_gen      <= w_gen_n;
      r_chk      <= w_chk_n;
      r_err      <= w_err_n;
      r_out_v    <= w_out_v_n;
      r_in_ready <= w_in_ready_n;
      r_out_data <= w_out_data_n;
    end
  end

  // FIFO storage; contents are don't-care while empty so no reset is needed
  always_ff @(posedge clk_i) begin
    for (int c = 0; c < num_channels_p; c++) begin
      if (w_we[c]) begin
        r_mem[c][r_wptr[c]] <= in_data_i[c];
      end
    end
  end

  assign in_ready_and_o = r_in_ready;
  assign out_v_o        = r_out_v;
  assign out_data_o     = r_out_data;
  assign err_count_o    = r_err;

`ifdef BSG_LINK_LOOPBACK_GEN_STATS_EN
  logic [num_channels_p-1:0][31:0] r_sent, r_recv;

  // Handshake counters, wrapping; mode load clears and discards its handshakes
  always_ff @(posedge clk_i) begin
    if (!reset_n_i || mode_v_i) begin
      r_sent <= '0;
      r_recv <= '0;
    end else begin
      for (int c = 0; c < num_channels_p; c++) begin
        if (w_out_hs[c]) r_sent[c] <= r_sent[c] + 32'(1);
        if (w_in_hs[c])  r_recv[c] <= r_recv[c] + 32'(1);
      end
    end
  end

  assign sent_count_o = r_sent;
  assign recv_count_o = r_recv;
`endif

endmodule
